alu_issue_stage: RTL and testbench

- Decode/issue stage that produces the opcode/funct/operand-select interface consumed by the ALU.
- Accepts 16-bit instruction words from fetch and decodes the ALU control fields, register specifiers and extended immediate.
- Buffers decoded entries in a 2-entry in-order skid buffer with valid/ready handshakes on both sides.
- Supports a synchronous pipeline flush.

---
 rtl/alu_issue_stage.sv | 164 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the ALU: decodes 16-bit instruction words at push time
// and holds them in a 2-entry in-order skid buffer with valid/ready on both sides.
module alu_issue_stage #(
  parameter int INSTR_WIDTH = 16,
  parameter int DEPTH       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4:0]             opcode,
  output logic [1:0]             funct,
  output logic [2:0]             rs,
  output logic [2:0]             rt,
  output logic [2:0]             rd,
  output logic [INSTR_WIDTH-1:0] imm,
  output logic                   use_imm,
  output logic                   alu_en,
  output logic                   reg_write
);

  typedef struct packed {
    logic [4:0]             opcode;
    logic [1:0]             funct;
    logic [2:0]             rs;
    logic [2:0]             rt;
    logic [2:0]             rd;
    logic [INSTR_WIDTH-1:0] imm;
    logic                   use_imm;
    logic                   alu_en;
    logic                   reg_write;
  } entry_t;

  localparam int         ENTRY_W  = $bits(entry_t);
  localparam logic [1:0] CNT_FULL = 2'(DEPTH);

  // Non-ALU classes pass a sign-extended imm5 through for downstream control.
  function automatic entry_t decode_f(input logic [INSTR_WIDTH-1:0] ins);
    entry_t     e;
    logic [4:0] opc;
    opc         = ins[INSTR_WIDTH-1 -: 5];
    e.opcode    = opc;
    e.funct     = ins[1:0];
    e.rs        = ins[10:8];
    e.rt        = ins[7:5];
    e.rd        = 3'd0;
    e.imm       = {{(INSTR_WIDTH-5){ins[4]}}, ins[4:0]};
    e.use_imm   = 1'b0;
    e.alu_en    = 1'b0;
    e.reg_write = 1'b0;
    case (opc[4:2])
      3'b010: begin
        e.rd        = ins[7:5];
        e.use_imm   = 1'b1;
        e.alu_en    = 1'b1;
        e.reg_write = 1'b1;
        if (opc[1]) begin
          e.imm = {{(INSTR_WIDTH-5){1'b0}}, ins[4:0]};
        end else begin
          e.imm = {{(INSTR_WIDTH-5){ins[4]}}, ins[4:0]};
        end
      end
      3'b101: begin
        e.rd        = ins[7:5];
        e.imm       = {{(INSTR_WIDTH-4){1'b0}}, ins[3:0]};
        e.use_imm   = 1'b1;
        e.alu_en    = 1'b1;
        e.reg_write = 1'b1;
      end
      3'b110: begin
        if (opc[1]) begin
          e.rd        = ins[4:2];
          e.imm       = {INSTR_WIDTH{1'b0}};
          e.alu_en    = 1'b1;
          e.reg_write = 1'b1;
        end else begin
          e.rd        = 3'd0;
        end
      end
      3'b111: begin
        e.rd        = ins[4:2];
        e.imm       = {INSTR_WIDTH{1'b0}};
        e.alu_en    = 1'b1;
        e.reg_write = 1'b1;
      end
      default: begin
        e.rd = 3'd0;
      end
    endcase
    return e;
  endfunction

  entry_t     head_r;
  entry_t     tail_r;
  entry_t     new_s;
  logic [1:0] count_r;
  logic       push_s;
  logic       pop_s;
  logic       valid_s;
  logic       ready_s;

  // handshake qualification from registered occupancy only
  always_comb begin
    ready_s = rst & (count_r != CNT_FULL);
    valid_s = (count_r != 2'd0);
    push_s  = in_valid & ready_s & ~flush;
    pop_s   = valid_s & out_ready & ~flush;
    new_s   = decode_f(instr);
  end

  // buffer update: head always holds the oldest entry so outputs come straight from flops
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= 2'd0;
      head_r  <= {ENTRY_W{1'b0}};
      tail_r  <= {ENTRY_W{1'b0}};
    end else if (flush) begin
      count_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_r <= new_s;
          end else begin
            tail_r <= new_s;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          head_r  <= tail_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            head_r <= new_s;
          end else begin
            head_r <= tail_r;
            tail_r <= new_s;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign in_ready  = ready_s;
  assign out_valid = valid_s;
  assign opcode    = head_r.opcode;
  assign funct     = head_r.funct;
  assign rs        = head_r.rs;
  assign rt        = head_r.rt;
  assign rd        = head_r.rd;
  assign imm       = head_r.imm;
  assign use_imm   = head_r.use_imm;
  assign alu_en    = head_r.alu_en;
  assign reg_write = head_r.reg_write;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: driver pushes expected decodes into a queue,
// a negedge monitor pops and compares whenever the stage presents an entry.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        in_ready, out_valid, use_imm, alu_en, reg_write;
  logic [4:0]  opcode;
  logic [1:0]  funct;
  logic [2:0]  rs, rt, rd;
  logic [15:0] imm;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
    .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .use_imm(use_imm),
    .alu_en(alu_en), .reg_write(reg_write)
  );

  typedef struct {
    logic [4:0]  opcode;
    logic [1:0]  funct;
    logic [2:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        use_imm, alu_en, reg_write;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   pend_pop = 1'b0;
  bit   started = 1'b0;

  // Reference decode written from the class table with integer arithmetic.
  function automatic exp_t ref_decode(input logic [15:0] w);
    exp_t e;
    int   cls, s5;
    e.opcode = w[15:11];
    e.funct  = w[1:0];
    e.rs     = w[10:8];
    e.rt     = w[7:5];
    s5  = w[4] ? int'(w[4:0]) - 32 : int'(w[4:0]);
    cls = int'(w[15:13]);
    e.rd = 3'd0; e.use_imm = 1'b0; e.alu_en = 1'b0; e.reg_write = 1'b0; e.imm = 16'(s5);
    if (cls == 2) begin
      e.rd = w[7:5]; e.use_imm = 1'b1; e.alu_en = 1'b1; e.reg_write = 1'b1;
      if (w[12]) e.imm = 16'(int'(w[4:0]));
    end else if (cls == 5) begin
      e.rd = w[7:5]; e.use_imm = 1'b1; e.alu_en = 1'b1; e.reg_write = 1'b1;
      e.imm = 16'(int'(w[3:0]));
    end else if ((cls == 6 && w[12]) || cls == 7) begin
      e.rd = w[4:2]; e.alu_en = 1'b1; e.reg_write = 1'b1; e.imm = 16'h0000;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: compare the presented entry with the scoreboard head, pop on handshake.
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 32'(in_ready), 32'(rst && (exp_q.size() < 2)));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("opcode", 32'(opcode), 32'(exp_q[0].opcode));
        chk("funct", 32'(funct), 32'(exp_q[0].funct));
        chk("rs", 32'(rs), 32'(exp_q[0].rs));
        chk("rt", 32'(rt), 32'(exp_q[0].rt));
        chk("rd", 32'(rd), 32'(exp_q[0].rd));
        chk("imm", 32'(imm), 32'(exp_q[0].imm));
        chk("use_imm", 32'(use_imm), 32'(exp_q[0].use_imm));
        chk("alu_en", 32'(alu_en), 32'(exp_q[0].alu_en));
        chk("reg_write", 32'(reg_write), 32'(exp_q[0].reg_write));
        if (out_ready && !flush && rst) begin
          void'(exp_q.pop_front());
          pend_pop = 1'b1;
        end
      end
    end
  end

  task automatic drv(input bit v, input logic [15:0] w, input bit r, input bit f);
    in_valid = v; instr = w; out_ready = r; flush = f;
  endtask

  // One clock: update the scoreboard for this edge, then leave inputs free to change.
  task automatic step(output bit pushed);
    int sz;
    @(posedge clk);
    sz = exp_q.size() + int'(pend_pop);
    pushed = 1'b0;
    if (!rst || flush) begin
      exp_q.delete();
    end else if (in_valid && sz < 2) begin
      exp_q.push_back(ref_decode(instr));
      pushed = 1'b1;
    end
    pend_pop = 1'b0;
    started = 1'b1;
    #2;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_ov"}, 32'(out_valid), 32'd0);
    chk({nm, "_fields"}, 32'({opcode, funct, rs, rt, rd, use_imm, alu_en, reg_write}), 32'd0);
    chk({nm, "_imm"}, 32'(imm), 32'd0);
  endtask

  bit p;
  logic [15:0] a_w, b_w, c_w;

  initial begin
    // 1. reset then single ADDI push
    rst = 1'b0;
    step(p); step(p);
    check_zero("reset");
    chk("rdy_in_reset", 32'(in_ready), 32'd0);
    rst = 1'b1; #1;
    chk("rdy_after_rel", 32'(in_ready), 32'd1);
    drv(1'b1, 16'h41F3, 1'b0, 1'b0); step(p);
    drv(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("addi_ov", 32'(out_valid), 32'd1);
    chk("addi_opc", 32'(opcode), 32'h08);
    chk("addi_imm", 32'(imm), 32'hFFF3);
    chk("addi_ctl", 32'({use_imm, rd, reg_write}), 32'({1'b1, 3'd7, 1'b1}));
    drv(1'b0, 16'h0000, 1'b1, 1'b0); step(p);

    // 2. XORI zero-extension, then register ADD while streaming
    drv(1'b1, 16'h503F, 1'b1, 1'b0); step(p);
    chk("xori_imm", 32'(imm), 32'h001F);
    drv(1'b1, 16'hD94C, 1'b1, 1'b0); step(p);
    chk("add_regs", 32'({rs, rt, rd, funct}), 32'({3'd1, 3'd2, 3'd3, 2'd0}));
    chk("add_ctl", 32'({use_imm, alu_en}), 32'({1'b0, 1'b1}));
    drv(1'b0, 16'h0000, 1'b1, 1'b0); step(p);

    // 3. backpressure: A,B accepted, C held until space frees
    a_w = 16'($urandom); b_w = 16'($urandom); c_w = 16'($urandom);
    drv(1'b1, a_w, 1'b0, 1'b0); step(p);
    drv(1'b1, b_w, 1'b0, 1'b0); step(p);
    chk("full_rdy", 32'(in_ready), 32'd0);
    drv(1'b1, c_w, 1'b0, 1'b0); step(p);
    chk("c_held", 32'(p), 32'd0);
    step(p); step(p);
    drv(1'b1, c_w, 1'b1, 1'b0);
    p = 1'b0;
    for (int i = 0; i < 6 && !p; i++) step(p);
    chk("c_accepted", 32'(p), 32'd1);
    drv(1'b0, 16'h0000, 1'b1, 1'b0);
    repeat (3) step(p);

    // 4. streaming at count 1
    drv(1'b1, 16'($urandom), 1'b0, 1'b0); step(p);
    for (int i = 0; i < 10; i++) begin
      drv(1'b1, 16'($urandom), 1'b1, 1'b0); step(p);
      chk("stream_rdy", 32'(in_ready), 32'd1);
      chk("stream_push", 32'(p), 32'd1);
    end
    drv(1'b0, 16'h0000, 1'b1, 1'b0); step(p);

    // 5. flush with full buffer and a same-cycle push
    drv(1'b1, 16'($urandom), 1'b0, 1'b0); step(p);
    drv(1'b1, 16'($urandom), 1'b0, 1'b0); step(p);
    drv(1'b1, 16'hA123, 1'b1, 1'b1); step(p);
    chk("flush_ov", 32'(out_valid), 32'd0);
    chk("flush_rdy", 32'(in_ready), 32'd1);
    drv(1'b0, 16'h0000, 1'b1, 1'b0); step(p);
    chk("flush_drop", 32'(out_valid), 32'd0);

    // 6. non-ALU branch, then reset with a full buffer
    drv(1'b1, {5'b01100, 11'h2A5}, 1'b0, 1'b0); step(p);
    chk("branch_ctl", 32'({alu_en, reg_write}), 32'd0);
    drv(1'b1, 16'($urandom), 1'b0, 1'b0); step(p);
    drv(1'b0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0; step(p);
    check_zero("midrst");
    rst = 1'b1;

    // 7. random traffic
    for (int i = 0; i < 800; i++) begin
      drv(1'($urandom % 4 != 0), 16'($urandom), 1'($urandom % 3 != 0), 1'($urandom % 16 == 0));
      rst = 1'($urandom % 64 != 0);
      step(p);
    end
    rst = 1'b1;
    drv(1'b0, 16'h0000, 1'b1, 1'b0);
    repeat (4) step(p);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
